iddmm_mul_pipe: RTL

IDDMM_MUL_PIPE -- requirements
Module: iddmm_mul_pipe

---
 rtl/iddmm_pkg.sv | 20 ++
 rtl/iddmm_pp_gen.sv | 19 +
 rtl/iddmm_mul_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM multiplier pipeline:
// mode encoding, default limb widths and pipeline depth.
package iddmm_pkg;

    typedef enum logic [1:0] {
        MODE_FULL = 2'b00,
        MODE_LO   = 2'b01,
        MODE_HI   = 2'b10,
        MODE_SQR  = 2'b11
    } mode_t;

    localparam int XW_DEF   = 24;
    localparam int YW_DEF   = 16;
    localparam int N_STAGES = 5;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/iddmm_pp_gen.sv
// Partial products of one X limb against every Y limb,
// packed limb 0 in the least significant slot.
module iddmm_pp_gen #(
    parameter int XW = 24,
    parameter int YW = 16,
    parameter int NY = 8
) (
    input  logic [XW-1:0]           xl,
    input  logic [NY*YW-1:0]        y,
    output logic [NY*(XW+YW)-1:0]   pp
);

    localparam int PW = XW + YW;

    for (genvar j = 0; j < NY; j++) begin : g_limb
        assign pp[j*PW +: PW] = PW'(xl) * PW'(y[j*YW +: YW]);
    end

endmodule

// File: rtl/iddmm_mul_pipe.sv
// Five-stage K x K limb multiplier with full/low/high/square modes,
// a global stall enable and a tag carried alongside each operation.
module iddmm_mul_pipe
    import iddmm_pkg::*;
#(
    parameter int K  = 128,
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int TW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [K-1:0]    x,
    input  logic [K-1:0]    y,
    input  logic [1:0]      mode,
    input  logic [TW-1:0]   in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*K-1:0]  result,
    output logic [TW-1:0]   out_tag,
    output logic            busy
);

    localparam int NX = ceil_div(K, XW);
    localparam int NY = ceil_div(K, YW);
    localparam int PW = XW + YW;
    localparam int RW = XW + NY * YW;
    localparam int AW = NX * XW + NY * YW;
    localparam int W2 = 2 * K;
    localparam int NH = NX / 2;

    logic                   en;
    logic [N_STAGES-1:0]    vld;
    mode_t                  md [N_STAGES-1];
    logic [TW-1:0]          tg [N_STAGES];

    logic [NX*XW-1:0]       x_pad;
    logic [NY*YW-1:0]       y_pad;
    logic [NX*NY*PW-1:0]    pp_d;
    logic [NX*NY*PW-1:0]    s0_pp;
    logic [NX*RW-1:0]       row_d;
    logic [NX*RW-1:0]       s1_row;
    logic [W2-1:0]          h0_d;
    logic [W2-1:0]          h1_d;
    logic [W2-1:0]          s2_h0;
    logic [W2-1:0]          s2_h1;
    logic [W2-1:0]          s3_p;
    logic [W2-1:0]          res_d;

    assign en        = !vld[N_STAGES-1] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld[N_STAGES-1];
    assign out_tag   = tg[N_STAGES-1];
    assign busy      = |vld;

    // Squaring reuses x on the Y side so y is ignored entirely.
    always_comb begin
        x_pad = '0;
        y_pad = '0;
        x_pad[K-1:0] = x;
        y_pad[K-1:0] = (mode_t'(mode) == MODE_SQR) ? x : y;
    end

    for (genvar i = 0; i < NX; i++) begin : g_pp
        iddmm_pp_gen #(
            .XW (XW),
            .YW (YW),
            .NY (NY)
        ) u_pp (
            .xl (x_pad[i*XW +: XW]),
            .y  (y_pad),
            .pp (pp_d[i*NY*PW +: NY*PW])
        );
    end

    always_comb begin
        row_d = '0;
        for (int i = 0; i < NX; i++) begin
            for (int j = 0; j < NY; j++) begin
                row_d[i*RW +: RW] = row_d[i*RW +: RW]
                    + (RW'(s0_pp[(i*NY+j)*PW +: PW]) << (j*YW));
            end
        end
    end

    // Every partial sum is bounded by the full product, so 2K bits suffice.
    always_comb begin
        h0_d = '0;
        h1_d = '0;
        for (int i = 0; i < NX; i++) begin
            if (i < NH) begin
                h0_d = h0_d + W2'(AW'(s1_row[i*RW +: RW]) << (i*XW));
            end else begin
                h1_d = h1_d + W2'(AW'(s1_row[i*RW +: RW]) << (i*XW));
            end
        end
    end

    always_comb begin
        res_d = s3_p;
        unique case (md[N_STAGES-2])
            MODE_LO:   res_d = {{K{1'b0}}, s3_p[K-1:0]};
            MODE_HI:   res_d = {{K{1'b0}}, s3_p[W2-1:K]};
            MODE_FULL: res_d = s3_p;
            MODE_SQR:  res_d = s3_p;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            s0_pp  <= '0;
            s1_row <= '0;
            s2_h0  <= '0;
            s2_h1  <= '0;
            s3_p   <= '0;
            result <= '0;
            for (int s = 0; s < N_STAGES-1; s++) md[s] <= MODE_FULL;
            for (int s = 0; s < N_STAGES; s++) tg[s] <= '0;
        end else if (en) begin
            vld    <= {vld[N_STAGES-2:0], in_valid};
            s0_pp  <= pp_d;
            s1_row <= row_d;
            s2_h0  <= h0_d;
            s2_h1  <= h1_d;
            s3_p   <= s2_h0 + s2_h1;
            result <= res_d;
            md[0]  <= mode_t'(mode);
            for (int s = 1; s < N_STAGES-1; s++) md[s] <= md[s-1];
            tg[0]  <= in_tag;
            for (int s = 1; s < N_STAGES; s++) tg[s] <= tg[s-1];
        end
    end

endmodule
